// File: rtl/conv_pkg.sv
// Shared convolution-pipeline types and the signed-sum to unsigned-pixel
// saturation used by both the kernel stage and the result writer.
package conv_pkg;

  localparam int PIX_W = 8;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             eol;
    logic             eof;
  } out_beat_t;

  // Callers sign-extend their sum to 32 bits; the shift is arithmetic.
  function automatic logic [PIX_W-1:0] sat_u8(input logic signed [31:0] sum,
                                               input int shift);
    logic signed [31:0] s;
    s = sum >>> shift;
    if (s < 0)
      return '0;
    else if (s > 255)
      return 8'hFF;
    else
      return s[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// when a pop happens on the same edge. Head shows the last-popped word when empty.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [DW-1:0] last_reg;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign level   = level_reg;
  assign rdata   = empty ? last_reg : mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (push_ok && !clear)
      mem[wr_ptr_reg] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      last_reg   <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      last_reg   <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        last_reg   <= mem[rd_ptr_reg];
      end
      if (push_ok && !pop_ok)
        level_reg <= level_reg + 1'b1;
      else if (pop_ok && !push_ok)
        level_reg <= level_reg - 1'b1;
    end
  end

endmodule

// File: rtl/conv_result_writer.sv
// Scales/saturates each convolution sum to a pixel, tags line/frame ends,
// and drains results through a FIFO over a ready/valid byte interface.
module conv_result_writer
  import conv_pkg::*;
#(
  parameter int W     = 128,
  parameter int H     = 128,
  parameter int IN_W  = 16,
  parameter int SHIFT = 0,
  parameter int DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic signed [IN_W-1:0]        in_sum,
  output logic [PIX_W-1:0]              out_data,
  output logic                          out_eol,
  output logic                          out_eof,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic [$clog2(DEPTH):0]        level
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic          stage_valid_reg;
  out_beat_t     stage_beat_reg;
  logic          overflow_reg;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          at_eol;
  logic          at_eof;
  out_beat_t     head;

  assign at_eol = (col_reg == CW'(W-1));
  assign at_eof = at_eol && (row_reg == RW'(H-1));
  assign pop    = !fifo_empty && out_ready;

  // Counters move on every accepted input so a dropped result never shifts
  // the line/frame tags of the pixels that follow it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_reg         <= '0;
      row_reg         <= '0;
      stage_valid_reg <= 1'b0;
      stage_beat_reg  <= '0;
      overflow_reg    <= 1'b0;
    end else if (clear) begin
      col_reg         <= '0;
      row_reg         <= '0;
      stage_valid_reg <= 1'b0;
      stage_beat_reg  <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      stage_valid_reg <= in_valid;
      if (in_valid) begin
        stage_beat_reg.pix <= sat_u8(32'(in_sum), SHIFT);
        stage_beat_reg.eol <= at_eol;
        stage_beat_reg.eof <= at_eof;
        if (at_eol) begin
          col_reg <= '0;
          row_reg <= at_eof ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
      if (stage_valid_reg && fifo_full && !pop)
        overflow_reg <= 1'b1;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    ($bits(out_beat_t))
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (stage_valid_reg),
    .pop   (pop),
    .wdata (stage_beat_reg),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head.pix;
  assign out_eol   = head.eol;
  assign out_eof   = head.eof;
  assign overflow  = overflow_reg;

endmodule
